// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit output stage: FSM state encodings and
// the default bit period.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // 50 MHz / 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_tx_out_if.sv
// Four-phase start/finish byte handshake between the FIFO-drain stage (master)
// and the UART transmitter (slave).
interface uart_tx_out_if;

    logic [7:0] in_data;
    logic       in_start;
    logic       in_finish;

    modport master (
        output in_data,
        output in_start,
        input  in_finish
    );

    modport slave (
        input  in_data,
        input  in_start,
        output in_finish
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period; held at zero while cleared.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_count;

    assign o_tick = (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clear || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_out.sv
// 8N1 UART transmitter fed by a four-phase start/finish handshake; in_finish is
// raised only after the stop bit has been fully driven.
module uart_tx_out
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_out_if.slave         bus,
    output logic                 tx,
    output logic                 busy,
    output logic [2:0]           state
);

    logic [2:0] r_state;
    logic [7:0] r_shreg;
    logic [2:0] r_bit_idx;
    logic       r_tx;
    logic       r_busy;
    logic       r_finish;
    logic       w_tick;
    logic       w_clear;

    // Counter only runs while a bit is on the line, so every frame starts aligned.
    assign w_clear = !((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP));

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (bus.in_start && !r_finish) begin
                        r_shreg   <= bus.in_data;
                        r_bit_idx <= '0;
                        r_busy    <= 1'b1;
                        r_tx      <= 1'b0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shreg[0];
                        r_shreg <= {1'b0, r_shreg[7:1]};
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shreg[0];
                            r_shreg   <= {1'b0, r_shreg[7:1]};
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_busy   <= 1'b0;
                        r_finish <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_tx <= 1'b1;
                    if (!bus.in_start) begin
                        r_finish <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx     <= 1'b1;
                    r_busy   <= 1'b0;
                    r_finish <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_finish = r_finish;
    assign tx            = r_tx;
    assign busy          = r_busy;
    assign state         = r_state;

endmodule

// File: tb/tb_uart_tx_out.sv
// Directed bench for uart_tx_out: short-period instance for frame-level checks,
// full-rate instance driven by an upstream handshake model and a UART receiver.
module tb_uart_tx_out;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx4, busy4, tx434, busy434;
    logic [2:0] st4, st434;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    uart_tx_out_if bus4 ();
    uart_tx_out_if bus434 ();

    uart_tx_out #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus4),
        .tx    (tx4),
        .busy  (busy4),
        .state (st4)
    );

    uart_tx_out #(.CLKS_PER_BIT(434)) u_dut434 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus434),
        .tx    (tx434),
        .busy  (busy434),
        .state (st434)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise in_start and record tx/busy for the 40 cycles following acceptance.
    task automatic run_frame4(input logic [7:0] b, output logic [39:0] txv, output int busy_cnt);
        bus4.in_data  = b;
        bus4.in_start = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            txv[c] = tx4;
            if (busy4 === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.in_start = 1'b0;
        bus4.in_data = 8'h00;
        bus434.in_start = 1'b0;
        bus434.in_data = 8'h00;
        tick();
        tick();
        checks++;
        if ({tx4, busy4, bus4.in_finish, st4} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset4: tx/busy/fin/state=%b%b%b/%0d required 100/0",
                     tx4, busy4, bus4.in_finish, st4);
        end
        checks++;
        if ({tx434, busy434, bus434.in_finish, st434} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset434: tx/busy/fin/state=%b%b%b/%0d required 100/0",
                     tx434, busy434, bus434.in_finish, st434);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (st4 !== 3'd0 || tx4 !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: state=%0d tx=%b required 0/1", st4, tx4);
        end
    endtask

    task automatic test_frame_55();
        logic [39:0] txv;
        int bc;
        int bad;
        run_frame4(8'h55, txv, bc);
        checks++;
        if (txv !== 40'hF0F0F0F0F0) begin
            errors++;
            $display("FAIL frame55_tx: got %h required %h", txv, 40'hF0F0F0F0F0);
        end
        checks++;
        if (bus4.in_finish !== 1'b0) begin
            errors++;
            $display("FAIL frame55_early_fin: in_finish=%b required 0", bus4.in_finish);
        end
        tick();
        checks++;
        if ({bus4.in_finish, busy4, tx4, st4} !== {1'b1, 1'b0, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL frame55_done: fin/busy/tx/state=%b%b%b/%0d required 101/4",
                     bus4.in_finish, busy4, tx4, st4);
        end
        bad = 0;
        repeat (3) begin
            tick();
            if (bus4.in_finish !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame55_fin_hold: %0d cycles low required 0", bad);
        end
        bus4.in_start = 1'b0;
        tick();
        checks++;
        if (bus4.in_finish !== 1'b0 || st4 !== 3'd0) begin
            errors++;
            $display("FAIL frame55_release: fin=%b state=%0d required 0/0", bus4.in_finish, st4);
        end
    endtask

    task automatic test_extremes();
        logic [39:0] txv;
        int bc;
        run_frame4(8'h00, txv, bc);
        tick();
        checks++;
        if (txv !== 40'hF000000000 || bc != 40) begin
            errors++;
            $display("FAIL byte00: tx=%h busy_cycles=%0d required F000000000/40", txv, bc);
        end
        checks++;
        if (busy4 !== 1'b0 || bus4.in_finish !== 1'b1) begin
            errors++;
            $display("FAIL byte00_end: busy=%b fin=%b required 0/1", busy4, bus4.in_finish);
        end
        bus4.in_start = 1'b0;
        tick();
        run_frame4(8'hFF, txv, bc);
        tick();
        checks++;
        if (txv !== 40'hFFFFFFFFF0 || bc != 40) begin
            errors++;
            $display("FAIL byteFF: tx=%h busy_cycles=%0d required FFFFFFFFF0/40", txv, bc);
        end
        bus4.in_start = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [39:0] txv;
        int bc;
        int bad;
        run_frame4(8'h81, txv, bc);
        tick();
        bad = 0;
        repeat (100) begin
            tick();
            if (tx4 !== 1'b1 || st4 !== 3'd4 || bus4.in_finish !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL held_start: %0d bad cycles required 0", bad);
        end
        bus4.in_start = 1'b0;
        tick();
        checks++;
        if (bus4.in_finish !== 1'b0 || st4 !== 3'd0) begin
            errors++;
            $display("FAIL rerequest_idle: fin=%b state=%0d required 0/0", bus4.in_finish, st4);
        end
        bus4.in_start = 1'b1;
        tick();
        checks++;
        if (tx4 !== 1'b0 || st4 !== 3'd1 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL rerequest_start: tx=%b state=%0d busy=%b required 0/1/1",
                     tx4, st4, busy4);
        end
        repeat (40) tick();
        checks++;
        if (bus4.in_finish !== 1'b1) begin
            errors++;
            $display("FAIL rerequest_fin: in_finish=%b required 1", bus4.in_finish);
        end
        bus4.in_start = 1'b0;
        tick();
    endtask

    task automatic test_data_latch();
        logic [39:0] txv;
        logic [7:0] d;
        bus4.in_data  = 8'h3C;
        bus4.in_start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            txv[c] = tx4;
            if (c == 9) bus4.in_data = 8'hAA;
        end
        for (int i = 0; i < 8; i++) d[i] = txv[4 * (i + 1) + 2];
        checks++;
        if (d !== 8'h3C || txv !== 40'hF00FFFF000) begin
            errors++;
            $display("FAIL latch: decoded=%h tx=%h required 3C/F00FFFF000", d, txv);
        end
        tick();
        bus4.in_start = 1'b0;
        tick();
    endtask

    task automatic test_reset_midframe();
        logic [39:0] txv;
        int bc;
        bus4.in_data  = 8'h00;
        bus4.in_start = 1'b1;
        repeat (17) tick();
        checks++;
        if (st4 !== 3'd2 || tx4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_state: state=%0d tx=%b required 2/0", st4, tx4);
        end
        rst = 1'b1;
        bus4.in_start = 1'b0;
        tick();
        checks++;
        if ({tx4, busy4, bus4.in_finish, st4} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL mid_reset: tx/busy/fin/state=%b%b%b/%0d required 100/0",
                     tx4, busy4, bus4.in_finish, st4);
        end
        rst = 1'b0;
        tick();
        run_frame4(8'hA5, txv, bc);
        tick();
        checks++;
        if (txv !== 40'hFF0F00F0F0 || bc != 40 || bus4.in_finish !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: tx=%h busy=%0d fin=%b required FF0F00F0F0/40/1",
                     txv, bc, bus4.in_finish);
        end
        bus4.in_start = 1'b0;
        tick();
    endtask

    task automatic test_full_rate();
        logic [7:0] bytes [3];
        logic [7:0] rx;
        int fall [3];
        int n;
        bytes[0] = 8'h01;
        bytes[1] = 8'h80;
        bytes[2] = 8'h7E;
        for (int k = 0; k < 3; k++) begin
            bus434.in_data  = bytes[k];
            bus434.in_start = 1'b1;
            n = 0;
            while (tx434 !== 1'b0 && n < 100) begin
                tick();
                n++;
            end
            fall[k] = cyc;
            checks++;
            if (tx434 !== 1'b0) begin
                errors++;
                $display("FAIL rx%0d_start_timeout: tx=%b required 0", k, tx434);
            end
            repeat (217) tick();
            checks++;
            if (tx434 !== 1'b0) begin
                errors++;
                $display("FAIL rx%0d_start_bit: tx=%b required 0", k, tx434);
            end
            for (int i = 0; i < 8; i++) begin
                repeat (434) tick();
                rx[i] = tx434;
            end
            repeat (434) tick();
            checks++;
            if (tx434 !== 1'b1) begin
                errors++;
                $display("FAIL rx%0d_stop_bit: tx=%b required 1", k, tx434);
            end
            checks++;
            if (rx !== bytes[k]) begin
                errors++;
                $display("FAIL rx%0d_byte: got %h required %h", k, rx, bytes[k]);
            end
            n = 0;
            while (bus434.in_finish !== 1'b1 && n < 500) begin
                tick();
                n++;
            end
            checks++;
            if (bus434.in_finish !== 1'b1) begin
                errors++;
                $display("FAIL rx%0d_finish_timeout: in_finish=%b required 1", k, bus434.in_finish);
            end
            bus434.in_start = 1'b0;
            n = 0;
            while (bus434.in_finish !== 1'b0 && n < 10) begin
                tick();
                n++;
            end
            if (k > 0) begin
                checks++;
                if (fall[k] - (fall[k - 1] + 9 * 434) < 434) begin
                    errors++;
                    $display("FAIL rx%0d_idle: %0d high cycles required >= 434",
                             k, fall[k] - (fall[k - 1] + 9 * 434));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_extremes();
        test_back_to_back();
        test_data_latch();
        test_reset_midframe();
        test_full_rate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
